// File: rtl/ysyx_24080014_pkg.sv
// Shared encodings for the NPC memory arbiter: FSM states, load sizes and owner ids.
package ysyx_24080014_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } state_e;

   localparam logic [2:0] RMASK_B = 3'b001;
   localparam logic [2:0] RMASK_H = 3'b010;
   localparam logic [2:0] RMASK_W = 3'b100;

   localparam logic OWNER_IFU = 1'b0;
   localparam logic OWNER_LSU = 1'b1;

endpackage

// File: rtl/ysyx_24080014_mem_arbiter_if.sv
// Bus bundle between IFU/LSU, the arbiter and the memory access block.
// master = arbiter view (it masters the memory port); slave = surrounding requesters + memory.
interface ysyx_24080014_mem_arbiter_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic          ifu_req_valid;
   logic          ifu_req_ready;
   logic [AW-1:0] ifu_addr;
   logic          ifu_resp_valid;
   logic [DW-1:0] ifu_rdata;

   logic          lsu_req_valid;
   logic          lsu_req_ready;
   logic          lsu_wen;
   logic [AW-1:0] lsu_addr;
   logic [DW-1:0] lsu_wdata;
   logic [7:0]    lsu_wmask;
   logic [2:0]    lsu_rmask;
   logic          lsu_resp_valid;
   logic [DW-1:0] lsu_rdata;

   logic          mem_req_valid;
   logic          mem_req_ready;
   logic          mem_wen;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [7:0]    mem_wmask;
   logic [2:0]    mem_rmask;
   logic          mem_resp_valid;
   logic [DW-1:0] mem_rdata;

   modport master (
      input  ifu_req_valid, ifu_addr,
      output ifu_req_ready, ifu_resp_valid, ifu_rdata,
      input  lsu_req_valid, lsu_wen, lsu_addr, lsu_wdata, lsu_wmask, lsu_rmask,
      output lsu_req_ready, lsu_resp_valid, lsu_rdata,
      output mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_wmask, mem_rmask,
      input  mem_req_ready, mem_resp_valid, mem_rdata
   );

   modport slave (
      output ifu_req_valid, ifu_addr,
      input  ifu_req_ready, ifu_resp_valid, ifu_rdata,
      output lsu_req_valid, lsu_wen, lsu_addr, lsu_wdata, lsu_wmask, lsu_rmask,
      input  lsu_req_ready, lsu_resp_valid, lsu_rdata,
      input  mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_wmask, mem_rmask,
      output mem_req_ready, mem_resp_valid, mem_rdata
   );

endinterface

// File: rtl/ysyx_24080014_rdata_ext.sv
// Zero-extends the raw memory word down to the requested load size.
module ysyx_24080014_rdata_ext
   import ysyx_24080014_pkg::*;
#(
   parameter int DW = 32
) (
   input  logic [2:0]    rmask_i,
   input  logic [DW-1:0] raw_i,
   output logic [DW-1:0] data_o
);

   always_comb begin
      case (rmask_i)
         RMASK_B: data_o = {{(DW-8){1'b0}}, raw_i[7:0]};
         RMASK_H: data_o = {{(DW-16){1'b0}}, raw_i[15:0]};
         default: data_o = raw_i;
      endcase
   end

endmodule

// File: rtl/ysyx_24080014_mem_arbiter.sv
// Round-robin IFU/LSU arbiter for the single data-memory port; one access in flight,
// IDLE -> ISSUE -> WAIT, with a one-cycle response pulse back to the owner.
module ysyx_24080014_mem_arbiter
   import ysyx_24080014_pkg::*;
#(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  logic                          clk,
   input  logic                          rst,
   ysyx_24080014_mem_arbiter_if.master   bus,
   output logic                          busy,
   output logic                          owner,
   output logic                          proto_err
);

   state_e        state_q, state_d;
   logic          owner_q, owner_d;
   logic          wen_q, wen_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic [7:0]    wmask_q, wmask_d;
   logic [2:0]    rmask_q, rmask_d;
   logic          perr_q, perr_d;

   logic          gnt_lsu, gnt_ifu, resp_fire;
   logic [DW-1:0] ext_data, resp_data;

   // On a conflict the requester that did not own the last access wins.
   always_comb begin
      gnt_lsu = bus.lsu_req_valid & (~bus.ifu_req_valid | (owner_q == OWNER_IFU));
      gnt_ifu = bus.ifu_req_valid & ~gnt_lsu;
   end

   always_comb begin
      state_d           = state_q;
      owner_d           = owner_q;
      wen_d             = wen_q;
      addr_d            = addr_q;
      wdata_d           = wdata_q;
      wmask_d           = wmask_q;
      rmask_d           = rmask_q;
      perr_d            = perr_q | (bus.mem_resp_valid & (state_q != ST_WAIT));
      bus.ifu_req_ready = 1'b0;
      bus.lsu_req_ready = 1'b0;
      bus.mem_req_valid = 1'b0;
      resp_fire         = 1'b0;
      case (state_q)
         ST_IDLE: begin
            bus.ifu_req_ready = gnt_ifu & ~rst;
            bus.lsu_req_ready = gnt_lsu & ~rst;
            if (gnt_lsu) begin
               state_d = ST_ISSUE;
               owner_d = OWNER_LSU;
               wen_d   = bus.lsu_wen;
               addr_d  = bus.lsu_addr;
               wdata_d = bus.lsu_wdata;
               wmask_d = bus.lsu_wmask;
               rmask_d = bus.lsu_rmask;
            end else if (gnt_ifu) begin
               state_d = ST_ISSUE;
               owner_d = OWNER_IFU;
               wen_d   = 1'b0;
               addr_d  = bus.ifu_addr;
               wdata_d = '0;
               wmask_d = '0;
               rmask_d = RMASK_W;
            end
         end
         ST_ISSUE: begin
            bus.mem_req_valid = 1'b1;
            if (bus.mem_req_ready) state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (bus.mem_resp_valid) begin
               resp_fire = ~rst;
               state_d   = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         owner_q <= OWNER_IFU;
         wen_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         wmask_q <= '0;
         rmask_q <= '0;
         perr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         wen_q   <= wen_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         wmask_q <= wmask_d;
         rmask_q <= rmask_d;
         perr_q  <= perr_d;
      end
   end

   ysyx_24080014_rdata_ext #(.DW(DW)) u_ext (
      .rmask_i (rmask_q),
      .raw_i   (bus.mem_rdata),
      .data_o  (ext_data)
   );

   assign resp_data          = wen_q ? '0 : ext_data;
   assign bus.ifu_resp_valid = resp_fire & (owner_q == OWNER_IFU);
   assign bus.lsu_resp_valid = resp_fire & (owner_q == OWNER_LSU);
   assign bus.ifu_rdata      = bus.ifu_resp_valid ? resp_data : '0;
   assign bus.lsu_rdata      = bus.lsu_resp_valid ? resp_data : '0;

   assign bus.mem_wen   = wen_q;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;
   assign bus.mem_wmask = wmask_q;
   assign bus.mem_rmask = rmask_q;

   assign busy      = (state_q != ST_IDLE);
   assign owner     = owner_q;
   assign proto_err = perr_q;

endmodule

// File: tb/tb_ysyx_24080014_mem_arbiter.sv
// Directed bench for the IFU/LSU memory arbiter: a transaction table plus hand-written
// sequences for stalls, stray responses and reset mid-access.
module tb_ysyx_24080014_mem_arbiter;

   logic clk = 1'b0;
   logic rst;
   logic busy, owner, proto_err;
   int   checks = 0;
   int   errs   = 0;

   always #5 clk = ~clk;

   ysyx_24080014_mem_arbiter_if #(.AW(32), .DW(32)) bus ();

   ysyx_24080014_mem_arbiter #(.AW(32), .DW(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .busy      (busy),
      .owner     (owner),
      .proto_err (proto_err)
   );

   typedef struct {
      logic        ifu_v;
      logic        lsu_v;
      logic [31:0] ifu_addr;
      logic        lsu_wen;
      logic [31:0] lsu_addr;
      logic [31:0] lsu_wdata;
      logic [7:0]  lsu_wmask;
      logic [2:0]  lsu_rmask;
      logic [31:0] mem_rdata;
      logic        exp_owner;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t vecs [9];

   function automatic vec_t mk(input logic iv, input logic lv, input logic [31:0] ia,
                               input logic w, input logic [31:0] la, input logic [31:0] wd,
                               input logic [7:0] wm, input logic [2:0] rm,
                               input logic [31:0] md, input logic eo, input logic [31:0] erd);
      vec_t v;
      v.ifu_v = iv; v.lsu_v = lv; v.ifu_addr = ia; v.lsu_wen = w; v.lsu_addr = la;
      v.lsu_wdata = wd; v.lsu_wmask = wm; v.lsu_rmask = rm; v.mem_rdata = md;
      v.exp_owner = eo; v.exp_rdata = erd;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %08h want %08h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Entered and left at posedge+1 with the arbiter in IDLE.
   task automatic run_txn(input int idx, input vec_t v);
      string       tag;
      logic [31:0] e_addr, e_wdata;
      logic [7:0]  e_wmask;
      logic [2:0]  e_rmask;
      logic        e_wen;
      tag = $sformatf("v%0d", idx);
      if (v.exp_owner) begin
         e_addr = v.lsu_addr; e_wen = v.lsu_wen; e_wdata = v.lsu_wdata;
         e_wmask = v.lsu_wmask; e_rmask = v.lsu_rmask;
      end else begin
         e_addr = v.ifu_addr; e_wen = 1'b0; e_wdata = '0; e_wmask = '0; e_rmask = 3'b100;
      end
      bus.ifu_req_valid = v.ifu_v;  bus.ifu_addr  = v.ifu_addr;
      bus.lsu_req_valid = v.lsu_v;  bus.lsu_wen   = v.lsu_wen;
      bus.lsu_addr      = v.lsu_addr; bus.lsu_wdata = v.lsu_wdata;
      bus.lsu_wmask     = v.lsu_wmask; bus.lsu_rmask = v.lsu_rmask;
      bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b0;
      #1;
      chk({tag, " ifu_ready"}, 32'(bus.ifu_req_ready), 32'(!v.exp_owner));
      chk({tag, " lsu_ready"}, 32'(bus.lsu_req_ready), 32'(v.exp_owner));
      cyc();
      if (v.exp_owner) bus.lsu_req_valid = 1'b0; else bus.ifu_req_valid = 1'b0;
      #1;
      chk({tag, " owner"}, 32'(owner), 32'(v.exp_owner));
      chk({tag, " busy"}, 32'(busy), 32'd1);
      chk({tag, " mem_req_valid"}, 32'(bus.mem_req_valid), 32'd1);
      chk({tag, " mem_addr"}, bus.mem_addr, e_addr);
      chk({tag, " mem_wen"}, 32'(bus.mem_wen), 32'(e_wen));
      chk({tag, " mem_wdata"}, bus.mem_wdata, e_wdata);
      chk({tag, " mem_wmask"}, 32'(bus.mem_wmask), 32'(e_wmask));
      chk({tag, " mem_rmask"}, 32'(bus.mem_rmask), 32'(e_rmask));
      chk({tag, " ready_busy"}, 32'({bus.ifu_req_ready, bus.lsu_req_ready}), 32'd0);
      bus.mem_req_ready = 1'b1;
      cyc();
      bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b1; bus.mem_rdata = v.mem_rdata;
      #1;
      chk({tag, " ifu_resp"}, 32'(bus.ifu_resp_valid), 32'(!v.exp_owner));
      chk({tag, " lsu_resp"}, 32'(bus.lsu_resp_valid), 32'(v.exp_owner));
      chk({tag, " rdata"}, v.exp_owner ? bus.lsu_rdata : bus.ifu_rdata, v.exp_rdata);
      chk({tag, " other_rdata"}, v.exp_owner ? bus.ifu_rdata : bus.lsu_rdata, 32'd0);
      chk({tag, " ready_wait"}, 32'({bus.ifu_req_ready, bus.lsu_req_ready}), 32'd0);
      cyc();
      bus.mem_resp_valid = 1'b0;
   endtask

   initial begin
      vecs[0] = mk(1, 1, 32'h8000_0000, 0, 32'h8000_0100, 32'h0, 8'h00, 3'b100,
                   32'h1111_1111, 1, 32'h1111_1111);
      vecs[1] = mk(1, 1, 32'h8000_0000, 1, 32'h8000_0104, 32'hAABB_CCDD, 8'h0F, 3'b000,
                   32'h2222_2222, 0, 32'h2222_2222);
      vecs[2] = mk(1, 1, 32'h8000_0004, 0, 32'h8000_0203, 32'h0, 8'h00, 3'b001,
                   32'hDEAD_BEEF, 1, 32'h0000_00EF);
      vecs[3] = mk(1, 1, 32'h8000_0004, 0, 32'h8000_0203, 32'h0, 8'h00, 3'b001,
                   32'h0010_0073, 0, 32'h0010_0073);
      vecs[4] = mk(1, 0, 32'h8000_0000, 0, 32'h0, 32'h0, 8'h00, 3'b000,
                   32'h0010_0073, 0, 32'h0010_0073);
      vecs[5] = mk(0, 1, 32'h0, 0, 32'h8000_0302, 32'h0, 8'h00, 3'b010,
                   32'hDEAD_BEEF, 1, 32'h0000_BEEF);
      vecs[6] = mk(0, 1, 32'h0, 0, 32'h8000_0300, 32'h0, 8'h00, 3'b011,
                   32'hCAFE_F00D, 1, 32'hCAFE_F00D);
      vecs[7] = mk(0, 1, 32'h0, 1, 32'h8000_0400, 32'h55AA_55AA, 8'h03, 3'b000,
                   32'hFFFF_FFFF, 1, 32'h0000_0000);
      vecs[8] = mk(1, 1, 32'h8000_0008, 0, 32'h8000_0500, 32'h0, 8'h00, 3'b100,
                   32'h8765_4321, 0, 32'h8765_4321);

      // Reset with both requesters pushing: nothing may be accepted.
      rst = 1'b1;
      bus.ifu_req_valid = 1'b1; bus.ifu_addr = 32'h8000_0000;
      bus.lsu_req_valid = 1'b1; bus.lsu_wen = 1'b1; bus.lsu_addr = 32'h8000_0040;
      bus.lsu_wdata = 32'hFFFF_FFFF; bus.lsu_wmask = 8'hFF; bus.lsu_rmask = 3'b100;
      bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b0; bus.mem_rdata = 32'h0;
      cyc();
      cyc();
      chk("rst ready", 32'({bus.ifu_req_ready, bus.lsu_req_ready}), 32'd0);
      chk("rst busy", 32'(busy), 32'd0);
      chk("rst owner", 32'(owner), 32'd0);
      chk("rst mem_req_valid", 32'(bus.mem_req_valid), 32'd0);
      chk("rst mem_addr", bus.mem_addr, 32'd0);
      chk("rst mem_wdata", bus.mem_wdata, 32'd0);
      chk("rst mem_fields", 32'({bus.mem_wen, bus.mem_wmask, bus.mem_rmask}), 32'd0);
      chk("rst resp", 32'({bus.ifu_resp_valid, bus.lsu_resp_valid}), 32'd0);
      chk("rst proto_err", 32'(proto_err), 32'd0);
      rst = 1'b0;
      bus.ifu_req_valid = 1'b0; bus.lsu_req_valid = 1'b0;
      cyc();

      for (int i = 0; i < 9; i++) run_txn(i, vecs[i]);
      bus.ifu_req_valid = 1'b0; bus.lsu_req_valid = 1'b0;
      #1;
      chk("post-table busy", 32'(busy), 32'd0);

      // Store held off by memory for three cycles.
      bus.lsu_req_valid = 1'b1; bus.lsu_wen = 1'b1; bus.lsu_addr = 32'h8000_1000;
      bus.lsu_wdata = 32'h1234_5678; bus.lsu_wmask = 8'h0F; bus.lsu_rmask = 3'b000;
      #1;
      chk("st ready", 32'(bus.lsu_req_ready), 32'd1);
      cyc();
      bus.lsu_req_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         if (k == 3) bus.mem_req_ready = 1'b1;
         #1;
         chk($sformatf("st%0d req_valid", k), 32'(bus.mem_req_valid), 32'd1);
         chk($sformatf("st%0d addr", k), bus.mem_addr, 32'h8000_1000);
         chk($sformatf("st%0d wdata", k), bus.mem_wdata, 32'h1234_5678);
         chk($sformatf("st%0d wmask_wen", k), 32'({bus.mem_wen, bus.mem_wmask}), 32'h10F);
         cyc();
      end
      bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b1; bus.mem_rdata = 32'hFFFF_FFFF;
      #1;
      chk("st resp", 32'({bus.ifu_resp_valid, bus.lsu_resp_valid}), 32'd1);
      chk("st rdata", bus.lsu_rdata, 32'd0);
      cyc();
      bus.mem_resp_valid = 1'b0;
      #1;
      chk("st done", 32'({busy, bus.lsu_resp_valid}), 32'd0);

      // Stray response while IDLE.
      bus.mem_resp_valid = 1'b1; bus.mem_rdata = 32'h1234_5678;
      #1;
      chk("stray resp", 32'({bus.ifu_resp_valid, bus.lsu_resp_valid}), 32'd0);
      chk("stray rdata", bus.ifu_rdata | bus.lsu_rdata, 32'd0);
      chk("stray perr_pre", 32'(proto_err), 32'd0);
      cyc();
      bus.mem_resp_valid = 1'b0;
      #1;
      chk("perr set", 32'(proto_err), 32'd1);
      cyc(); cyc(); cyc();
      chk("perr sticky", 32'(proto_err), 32'd1);

      // Reset while the IFU access is waiting on memory.
      bus.ifu_req_valid = 1'b1; bus.ifu_addr = 32'h8000_0010;
      #1;
      chk("rw ready", 32'(bus.ifu_req_ready), 32'd1);
      cyc();
      bus.ifu_req_valid = 1'b0; bus.mem_req_ready = 1'b1;
      cyc();
      bus.mem_req_ready = 1'b0;
      #1;
      chk("rw busy_wait", 32'(busy), 32'd1);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      #1;
      chk("rw busy", 32'(busy), 32'd0);
      chk("rw mem_req_valid", 32'(bus.mem_req_valid), 32'd0);
      chk("rw perr_cleared", 32'(proto_err), 32'd0);
      cyc();
      bus.mem_resp_valid = 1'b1; bus.mem_rdata = 32'hA5A5_A5A5;
      #1;
      chk("rw late_resp", 32'({bus.ifu_resp_valid, bus.lsu_resp_valid}), 32'd0);
      chk("rw late_rdata", bus.ifu_rdata, 32'd0);
      cyc();
      bus.mem_resp_valid = 1'b0;
      #1;
      chk("rw perr", 32'(proto_err), 32'd1);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
